// File: rtl/key_arp_pkg.sv
// Shared constants, direction type and set-bit search helpers for key_arpeggiator.
package key_arp_pkg;

  localparam int unsigned NUM_BTNS  = 5;
  localparam int unsigned BTN_LATCH = 0;
  localparam int unsigned BTN_CLEAR = 1;
  localparam int unsigned BTN_DIR   = 2;
  localparam int unsigned BTN_RND   = 4;

  localparam int unsigned MAX_KEYS = 64;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // First set bit at or above start; wraps to the lowest set bit.
  // Bits above the real key count are zero, so no explicit width argument is needed.
  function automatic logic [5:0] find_up(input logic [MAX_KEYS-1:0] set,
                                         input int unsigned start);
    logic [5:0] above;
    logic [5:0] lowest;
    logic       hit_above;
    logic       hit_any;
    above     = '0;
    lowest    = '0;
    hit_above = 1'b0;
    hit_any   = 1'b0;
    for (int unsigned i = 0; i < MAX_KEYS; i++) begin
      if (set[i]) begin
        if (i >= start && !hit_above) begin
          above     = 6'(i);
          hit_above = 1'b1;
        end
        if (!hit_any) begin
          lowest  = 6'(i);
          hit_any = 1'b1;
        end
      end
    end
    find_up = hit_above ? above : lowest;
  endfunction

  // First set bit at or below start; wraps to the highest set bit.
  function automatic logic [5:0] find_down(input logic [MAX_KEYS-1:0] set,
                                           input int unsigned start);
    logic [5:0] below;
    logic [5:0] highest;
    logic       hit_below;
    below     = '0;
    highest   = '0;
    hit_below = 1'b0;
    for (int unsigned i = 0; i < MAX_KEYS; i++) begin
      if (set[i]) begin
        if (i <= start) begin
          below     = 6'(i);
          hit_below = 1'b1;
        end
        highest = 6'(i);
      end
    end
    find_down = hit_below ? below : highest;
  endfunction

endpackage

// File: rtl/key_arpeggiator_btn_debounce.sv
// Two-flop synchroniser plus counter debouncer for one front-panel button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        rise  <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_arpeggiator.sv
// Held-key set with chord or one-hot arpeggio output; debounced front-panel buttons.
// Optional random step order is enabled by defining ARP_RANDOM_EN.
module key_arpeggiator
  import key_arp_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 27,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned STEP_CYCLES     = 2500000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key,
  input  logic [4:0]          btn,
  input  logic                mode_sw,
  output logic [NUM_KEYS-1:0] note,
  output logic                note_valid,
  output logic                step_pulse
);

  localparam int unsigned SW = $clog2(STEP_CYCLES);

  logic [NUM_KEYS-1:0] key_s1;
  logic [NUM_KEYS-1:0] key_s2;
  logic                mode_s1;
  logic                mode_s2;

  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] btn_rise;
  logic                unused_btn;

  logic                latch_en;
  dir_t                dir;
  logic [NUM_KEYS-1:0] held;
  logic [5:0]          idx;
  logic [SW-1:0]       step_cnt;
  logic                fresh;

  logic                latch_en_n;
  dir_t                dir_n;
  logic [NUM_KEYS-1:0] held_n;
  logic [5:0]          idx_n;
  logic [SW-1:0]       step_cnt_n;
  logic                fresh_n;
  logic [NUM_KEYS-1:0] note_n;
  logic                step_pulse_n;
  logic                tick;
  logic [MAX_KEYS-1:0] held_x;

`ifdef ARP_RANDOM_EN
  logic                rnd_en;
  logic                rnd_en_n;
  logic [15:0]         lfsr;
  int unsigned         cand;
`endif

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (btn[g]),
      .level(btn_level[g]),
      .rise (btn_rise[g])
    );
  end

  // Levels and the reserved button are not part of the note path.
`ifdef ARP_RANDOM_EN
  assign unused_btn = &{1'b0, btn_level, btn_rise[3]};
`else
  assign unused_btn = &{1'b0, btn_level, btn_rise[4:3]};
`endif

  assign held_x = MAX_KEYS'(held);
  assign tick   = (step_cnt == SW'(STEP_CYCLES - 1));

  always_comb begin
    latch_en_n   = latch_en;
    dir_n        = dir;
    held_n       = key_s2;
    idx_n        = idx;
    step_cnt_n   = '0;
    fresh_n      = fresh;
    note_n       = note;
    step_pulse_n = 1'b0;
`ifdef ARP_RANDOM_EN
    rnd_en_n     = rnd_en;
    cand         = 32'(lfsr) % NUM_KEYS;
    if (btn_rise[BTN_RND]) rnd_en_n = ~rnd_en;
`endif

    if (btn_rise[BTN_CLEAR])  held_n = '0;
    else if (latch_en)        held_n = held | key_s2;
    if (btn_rise[BTN_LATCH])  latch_en_n = ~latch_en;
    if (btn_rise[BTN_DIR])    dir_n = (dir == DIR_UP) ? DIR_DOWN : DIR_UP;

    if (!mode_s2) begin
      note_n  = held;
      fresh_n = 1'b1;
    end else begin
      step_cnt_n = tick ? '0 : step_cnt + 1'b1;
      if (tick) begin
        if (held == '0) begin
          note_n  = '0;
          fresh_n = 1'b1;
        end else begin
          if (fresh)
            idx_n = (dir == DIR_UP) ? find_up(held_x, 0) : find_down(held_x, NUM_KEYS - 1);
          else if (dir == DIR_UP)
            idx_n = find_up(held_x, 32'(idx) + 1);
          else
            idx_n = find_down(held_x, (idx == '0) ? NUM_KEYS - 1 : 32'(idx) - 1);
`ifdef ARP_RANDOM_EN
          if (rnd_en) idx_n = find_up(held_x, cand);
`endif
          fresh_n      = 1'b0;
          step_pulse_n = 1'b1;
          for (int unsigned i = 0; i < NUM_KEYS; i++)
            note_n[i] = (idx_n == 6'(i));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      key_s1     <= '0;
      key_s2     <= '0;
      mode_s1    <= 1'b0;
      mode_s2    <= 1'b0;
      latch_en   <= 1'b0;
      dir        <= DIR_UP;
      held       <= '0;
      idx        <= '0;
      step_cnt   <= '0;
      fresh      <= 1'b1;
      note       <= '0;
      note_valid <= 1'b0;
      step_pulse <= 1'b0;
`ifdef ARP_RANDOM_EN
      rnd_en     <= 1'b0;
      lfsr       <= LFSR_SEED;
`endif
    end else begin
      key_s1     <= key;
      key_s2     <= key_s1;
      mode_s1    <= mode_sw;
      mode_s2    <= mode_s1;
      latch_en   <= latch_en_n;
      dir        <= dir_n;
      held       <= held_n;
      idx        <= idx_n;
      step_cnt   <= step_cnt_n;
      fresh      <= fresh_n;
      note       <= note_n;
      note_valid <= |note_n;
      step_pulse <= step_pulse_n;
`ifdef ARP_RANDOM_EN
      rnd_en     <= rnd_en_n;
      lfsr       <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
`endif
    end
  end

endmodule

// File: tb/tb_key_arpeggiator.sv
// Directed self-checking bench for key_arpeggiator (8 keys, short debounce and step period).
module tb_key_arpeggiator;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] key = '0;
  logic [4:0] btn = '0;
  logic       mode_sw = 1'b0;
  logic [7:0] note;
  logic       note_valid;
  logic       step_pulse;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails = 0;
  int unsigned gap;
  int unsigned pulses;

  always #5 clk = ~clk;

  key_arpeggiator #(
    .NUM_KEYS       (8),
    .DEBOUNCE_CYCLES(4),
    .STEP_CYCLES    (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key       (key),
    .btn       (btn),
    .mode_sw   (mode_sw),
    .note      (note),
    .note_valid(note_valid),
    .step_pulse(step_pulse)
  );

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int unsigned b);
    btn[b] = 1'b1;
    tick(6);
    btn[b] = 1'b0;
  endtask

  task automatic wait_pulse(output int unsigned n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (step_pulse !== 1'b1 && n < 40);
    check("pulse_seen", 64'(step_pulse), 64'd1);
  endtask

  initial begin
    tick(10);
    check("rst_note", 64'(note), 64'h0);
    check("rst_valid", 64'(note_valid), 64'd0);
    check("rst_pulse", 64'(step_pulse), 64'd0);
    check("rst_latch", 64'(dut.latch_en), 64'd0);
    check("rst_held", 64'(dut.held), 64'h0);
    reset = 1'b1;
    tick(2);

    key = 8'h05;
    tick(3);
    check("dir_lat3", 64'(note), 64'h0);
    tick(1);
    check("dir_lat4", 64'(note), 64'h05);
    check("dir_valid", 64'(note_valid), 64'd1);
    key = 8'h00;
    tick(3);
    check("dir_rel3", 64'(note), 64'h05);
    tick(1);
    check("dir_rel4", 64'(note), 64'h0);
    check("dir_rel_valid", 64'(note_valid), 64'd0);

    btn[0] = 1'b1;
    tick(3);
    btn[0] = 1'b0;
    tick(8);
    check("glitch_latch", 64'(dut.latch_en), 64'd0);
    press(0);
    tick(8);
    check("latch_on", 64'(dut.latch_en), 64'd1);

    key = 8'h01;
    tick(4);
    key = 8'h10;
    tick(4);
    key = 8'h00;
    tick(6);
    check("latched_held", 64'(dut.held), 64'h11);
    check("latched_note", 64'(note), 64'h11);

    press(1);
    tick(4);
    check("clear_held", 64'(dut.held), 64'h0);
    check("clear_note", 64'(note), 64'h0);
    check("clear_keeps_latch", 64'(dut.latch_en), 64'd1);
    key = 8'h29;
    tick(4);
    key = 8'h00;
    tick(4);
    check("load_held", 64'(dut.held), 64'h29);

    mode_sw = 1'b1;
    wait_pulse(gap);
    check("up_step0", 64'(note), 64'h01);
    check("up_valid", 64'(note_valid), 64'd1);
    wait_pulse(gap);
    check("up_step1", 64'(note), 64'h08);
    check("up_gap1", 64'(gap), 64'd8);
    wait_pulse(gap);
    check("up_step2", 64'(note), 64'h20);
    check("up_gap2", 64'(gap), 64'd8);
    wait_pulse(gap);
    check("up_step3", 64'(note), 64'h01);
    check("up_gap3", 64'(gap), 64'd8);
    tick(1);
    check("pulse_width", 64'(step_pulse), 64'd0);
    wait_pulse(gap);
    check("up_step4", 64'(note), 64'h08);

    press(2);
    wait_pulse(gap);
    check("dn_gap", 64'(gap), 64'd2);
    check("dn_step0", 64'(note), 64'h01);
    wait_pulse(gap);
    check("dn_step1", 64'(note), 64'h20);

    press(1);
    tick(1);
    check("empty_hold_note", 64'(note), 64'h20);
    tick(1);
    check("empty_note", 64'(note), 64'h0);
    check("empty_valid", 64'(note_valid), 64'd0);
    check("empty_pulse", 64'(step_pulse), 64'd0);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (step_pulse === 1'b1) pulses++;
    end
    check("empty_no_pulses", 64'(pulses), 64'd0);

    key = 8'h29;
    tick(4);
    key = 8'h00;
    wait_pulse(gap);
    check("dn_fresh", 64'(note), 64'h20);

    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    check("mid_rst_note", 64'(note), 64'h0);
    check("mid_rst_valid", 64'(note_valid), 64'd0);
    check("mid_rst_pulse", 64'(step_pulse), 64'd0);
    check("mid_rst_latch", 64'(dut.latch_en), 64'd0);
    check("mid_rst_held", 64'(dut.held), 64'h0);

    key = 8'h29;
    wait_pulse(gap);
    check("post_rst_up", 64'(note), 64'h01);

`ifdef ARP_RANDOM_EN
    press(4);
    for (int s = 0; s < 50; s++) begin
      wait_pulse(gap);
      check("rnd_subset", 64'(note & ~8'h29), 64'h0);
      check("rnd_onehot", 64'($countones(note)), 64'd1);
    end
    press(4);
`endif

    mode_sw = 1'b0;
    tick(5);
    check("back_direct", 64'(note), 64'h29);
    key = 8'h00;
    tick(5);
    check("unlatched_note", 64'(note), 64'h0);
    check("unlatched_held", 64'(dut.held), 64'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/key_arpeggiator.md
Name: key_arpeggiator

Overview:
- Parametrised successor to the fixed 27-key/5-button top-level note path.
- Takes a raw key vector and front-panel buttons, debounces the buttons, and maintains a held-key set that is either live or latched.
- Drives the note vector either directly (chord mode) or as a one-hot arpeggio stepping through held keys at a fixed rate.
- Sits between the keyboard/button inputs and the tone generators.

Parameters:
- NUM_KEYS, 27, width of key/note vectors (2..64)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles before a debounced button changes
- STEP_CYCLES, 2500000, clk cycles per arpeggio step (>=2)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- key  input  NUM_KEYS  raw key levels, asynchronous
- btn  input  5  raw buttons: [0] latch toggle, [1] clear, [2] direction toggle, [3] reserved, [4] random toggle (optional feature only)
- mode_sw  input  1  0 = chord/direct, 1 = arpeggio
- note  output  NUM_KEYS  active notes
- note_valid  output  1  registered, equals |note
- step_pulse  output  1  one-cycle pulse on each arpeggio step tick

Behaviour:
- Reset (reset==0 at posedge clk):
  - note=0, note_valid=0, step_pulse=0.
  - Debounced buttons=0, latch_en=0, dir=up, held=0, index=0, step counter=0, fresh=1.
- Synchronisers:
  - key, btn and mode_sw each pass through a 2-flop synchroniser.
- Debounce (per button):
  - Counter clears whenever the synchronised input equals the debounced level.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A one-cycle rise pulse fires on each 0->1 flip.
- Held set (updated every cycle):
  - Rise on btn[1] (clear) wins: held <= 0.
  - Else if latch_en: held <= held | key_sync.
  - Else: held <= key_sync.
  - Rise on btn[0] toggles latch_en. Clear and toggle on the same cycle: clear applies and latch_en toggles.
  - Rise on btn[2] toggles dir.
- Direct mode (mode_sw_sync==0):
  - note <= held every cycle.
  - Latency: key edge to note = 4 clk edges (2 sync, held, note).
  - Step counter held at 0, step_pulse=0, fresh=1.
- Arpeggio mode:
  - Step counter counts 0..STEP_CYCLES-1 and wraps; tick occurs when the counter equals STEP_CYCLES-1.
  - On tick with held==0: note<=0, fresh<=1, no step_pulse.
  - On tick with held!=0 and fresh:
    - up: index <= lowest set bit; down: index <= highest set bit.
    - fresh<=0.
  - On tick otherwise:
    - up: index <= next set bit strictly above index, wrapping to the lowest set bit.
    - down: index <= next set bit strictly below index, wrapping to the highest set bit.
    - A single held key repeats itself.
  - On every non-empty tick: note <= one-hot(new index), step_pulse=1 for that cycle.
  - Between ticks note holds, even if its key is released.
  - If held becomes 0 between ticks, note clears at the next tick.
- Mode change:
  - Arpeggio->direct takes effect the cycle after mode_sw_sync changes.
  - Direct->arpeggio: note holds its last direct value until the first tick, which uses fresh selection.
- Reset mid-step: discards all state, including latch_en and the accumulated held set.

Optional Feature:
- ARP_RANDOM_EN defined:
  - Rise on btn[4] toggles rnd_en; reset value 0.
  - Adds a 16-bit Galois LFSR, taps 0xB400, seed 0xACE1 at reset, advancing every cycle.
  - With rnd_en=1 on a non-empty tick: candidate = lfsr mod NUM_KEYS. If the candidate is held, it is chosen; otherwise the next set bit upward, with wrap, is chosen. dir is ignored.
- ARP_RANDOM_EN undefined: btn[4] is ignored, and no LFSR or rnd_en logic exists.

Decomposition:
- Package key_arp_pkg:
  - Button index constants BTN_LATCH=0, BTN_CLEAR=1, BTN_DIR=2, BTN_RND=4.
  - Direction encoding DIR_UP=0, DIR_DOWN=1.
  - LFSR seed and tap constants.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset, raw, level, rise), instantiated 5 times via generate.
- Next-set-bit search is a function in the package.

Test Plan:
- Bench parameters: NUM_KEYS=8, DEBOUNCE_CYCLES=4, STEP_CYCLES=8.
- Direct mode: reset 10 cycles, key=8'h05 -> note=8'h05 and note_valid=1 exactly 4 edges later; key=0 -> note=0 4 edges later.
- Debounce: btn[0] glitches high for 3 cycles -> latch_en unchanged. Held for 6 cycles -> latch_en=1. Then key=8'h01, key=8'h10 sequentially with key=0 after -> held=8'h11.
- Arpeggio up: held=8'h29, mode_sw=1 -> notes on successive step_pulses are 01,08,20,01; pulses are exactly 8 cycles apart.
- Direction and empty set: rise btn[2] during arpeggio on 8'h29 at note=08 -> next tick 01, then 20. Rise btn[1] (clear) with latch_en=1 -> next tick note=0, note_valid=0, no step_pulse.
- Reset mid-operation: reset=0 for one cycle during arpeggio with latch_en=1 -> all outputs 0, latch_en=0, held=0. With ARP_RANDOM_EN and rnd_en=1, every step_pulse note is one-hot and a subset of held, over 50 steps.
